// File: rtl/rob_mw_if.sv
// rob_mw_if: dispatch / wakeup / writeback / read / retire / redirect bundle for rob_mw.
// master = pipeline side (drives dispatch, wake, wb, read ids); slave = the reorder buffer.
interface rob_mw_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned RET_W  = 2,
    parameter int unsigned N_WB   = 2,
    parameter int unsigned N_WAKE = 1,
    parameter int unsigned N_RD   = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ARF_W  = 5
);
    localparam int unsigned ID_W = $clog2(DEPTH);

    logic                              dispatch_valid;
    logic                              dispatch_ready;
    logic [ID_W-1:0]                   dispatch_rob_id;
    logic                              dispatch_dst_valid;
    logic [ARF_W-1:0]                  dispatch_dst_arf_id;
    logic [XLEN-1:0]                   dispatch_pc;
    logic [N_WAKE-1:0]                 wake_valid;
    logic [N_WAKE-1:0][ID_W-1:0]       wake_rob_id;
    logic [N_WB-1:0]                   wb_valid;
    logic [N_WB-1:0][ID_W-1:0]         wb_rob_id;
    logic [N_WB-1:0][XLEN-1:0]         wb_data;
    logic [N_WB-1:0]                   wb_mispred;
    logic [N_WB-1:0][XLEN-1:0]         wb_npc;
    logic [N_RD-1:0][ID_W-1:0]         rd_rob_id;
    logic [N_RD-1:0]                   rd_ready;
    logic [N_RD-1:0][XLEN-1:0]         rd_data;
    logic [RET_W-1:0]                  retire_valid;
    logic [RET_W-1:0][ID_W-1:0]        retire_rob_id;
    logic [RET_W-1:0]                  retire_dst_valid;
    logic [RET_W-1:0][ARF_W-1:0]       retire_arf_id;
    logic [RET_W-1:0][XLEN-1:0]        retire_data;
    logic                              flush;
    logic [XLEN-1:0]                   flush_pc;

    modport master (
        output dispatch_valid, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_pc,
        output wake_valid, wake_rob_id,
        output wb_valid, wb_rob_id, wb_data, wb_mispred, wb_npc,
        output rd_rob_id,
        input  dispatch_ready, dispatch_rob_id, rd_ready, rd_data,
        input  retire_valid, retire_rob_id, retire_dst_valid, retire_arf_id, retire_data,
        input  flush, flush_pc
    );

    modport slave (
        input  dispatch_valid, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_pc,
        input  wake_valid, wake_rob_id,
        input  wb_valid, wb_rob_id, wb_data, wb_mispred, wb_npc,
        input  rd_rob_id,
        output dispatch_ready, dispatch_rob_id, rd_ready, rd_data,
        output retire_valid, retire_rob_id, retire_dst_valid, retire_arf_id, retire_data,
        output flush, flush_pc
    );
endinterface

// File: rtl/rob_mw.sv
// rob_mw: circular in-order reorder buffer with multi-port wakeup/writeback, operand reads,
// in-order multi-lane retire and head-mispredict redirect.
// Optional feature: define ROB_WB_BYPASS_EN to forward same-cycle wakeup/writeback to reads.
module rob_mw #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned RET_W  = 2,
    parameter int unsigned N_WB   = 2,
    parameter int unsigned N_WAKE = 1,
    parameter int unsigned N_RD   = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ARF_W  = 5
) (
    input logic     clk,
    input logic     rst_aH,
    rob_mw_if.slave bus_io
);
    localparam int unsigned ID_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W = ID_W + 1;

    // Pointers carry a wrap bit; count is kept explicitly and cross-checked against them.
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, done_q, done_d;
    logic [DEPTH-1:0] mispred_q, mispred_d, dst_valid_q, dst_valid_d;
    logic [ARF_W-1:0] arf_q  [DEPTH];
    logic [ARF_W-1:0] arf_d  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];
    logic [XLEN-1:0]  npc_q  [DEPTH];
    logic [XLEN-1:0]  npc_d  [DEPTH];

    logic [ID_W-1:0]  head_idx, tail_idx;
    logic [ID_W-1:0]  lane_idx [RET_W];
    logic [RET_W-1:0] ret_v;
    logic [PTR_W-1:0] n_ret;
    logic             full, flush, enq;

    assign head_idx = head_q[ID_W-1:0];
    assign tail_idx = tail_q[ID_W-1:0];
    assign full     = (count_q == PTR_W'(DEPTH));
    // Head mispredict wins over everything else this cycle.
    assign flush    = valid_q[head_idx] && done_q[head_idx] && mispred_q[head_idx];
    assign enq      = bus_io.dispatch_valid && !full && !flush;

    // Retire lanes: thermometer run of completed, non-mispredicted entries from the head.
    always_comb begin
        logic run;
        run   = 1'b1;
        n_ret = '0;
        for (int k = 0; k < RET_W; k++) begin
            lane_idx[k] = head_idx + ID_W'(k);
            run = run && valid_q[lane_idx[k]] && done_q[lane_idx[k]] &&
                  !mispred_q[lane_idx[k]] && (count_q > PTR_W'(k));
            ret_v[k] = run;
            n_ret    = n_ret + PTR_W'(run);
        end
    end

    // Next-state: flush clears everything; otherwise retire, wakeup, writeback, then dispatch.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        ready_d     = ready_q;
        done_d      = done_q;
        mispred_d   = mispred_q;
        dst_valid_d = dst_valid_q;
        arf_d       = arf_q;
        data_d      = data_q;
        npc_d       = npc_q;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            valid_d   = '0;
            ready_d   = '0;
            done_d    = '0;
            mispred_d = '0;
        end else begin
            for (int k = 0; k < RET_W; k++) begin
                if (ret_v[k]) begin
                    valid_d[lane_idx[k]]   = 1'b0;
                    ready_d[lane_idx[k]]   = 1'b0;
                    done_d[lane_idx[k]]    = 1'b0;
                    mispred_d[lane_idx[k]] = 1'b0;
                end
            end
            for (int p = 0; p < N_WAKE; p++) begin
                if (bus_io.wake_valid[p]) ready_d[bus_io.wake_rob_id[p]] = 1'b1;
            end
            for (int p = 0; p < N_WB; p++) begin
                if (bus_io.wb_valid[p]) begin
                    ready_d[bus_io.wb_rob_id[p]]   = 1'b1;
                    done_d[bus_io.wb_rob_id[p]]    = 1'b1;
                    mispred_d[bus_io.wb_rob_id[p]] = bus_io.wb_mispred[p];
                    data_d[bus_io.wb_rob_id[p]]    = bus_io.wb_data[p];
                    npc_d[bus_io.wb_rob_id[p]]     = bus_io.wb_npc[p];
                end
            end
            if (enq) begin
                valid_d[tail_idx]     = 1'b1;
                ready_d[tail_idx]     = 1'b0;
                done_d[tail_idx]      = 1'b0;
                mispred_d[tail_idx]   = 1'b0;
                dst_valid_d[tail_idx] = bus_io.dispatch_dst_valid;
                arf_d[tail_idx]       = bus_io.dispatch_dst_arf_id;
                data_d[tail_idx]      = '0;
                npc_d[tail_idx]       = '0;
            end
            head_d  = head_q + n_ret;
            tail_d  = tail_q + PTR_W'(enq);
            count_d = count_q + PTR_W'(enq) - n_ret;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            ready_q     <= '0;
            done_q      <= '0;
            mispred_q   <= '0;
            dst_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                arf_q[i]  <= '0;
                data_q[i] <= '0;
                npc_q[i]  <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            mispred_q   <= mispred_d;
            dst_valid_q <= dst_valid_d;
            arf_q       <= arf_d;
            data_q      <= data_d;
            npc_q       <= npc_d;
        end
    end

    // Outputs: dispatch/redirect status and retire lanes (zeroed when a lane is idle).
    always_comb begin
        bus_io.dispatch_ready  = !full && !flush;
        bus_io.dispatch_rob_id = tail_idx;
        bus_io.flush           = flush;
        bus_io.flush_pc        = flush ? npc_q[head_idx] : '0;
        bus_io.retire_valid    = ret_v;
        for (int k = 0; k < RET_W; k++) begin
            bus_io.retire_rob_id[k]    = ret_v[k] ? lane_idx[k] : '0;
            bus_io.retire_dst_valid[k] = ret_v[k] && dst_valid_q[lane_idx[k]];
            bus_io.retire_arf_id[k]    = ret_v[k] ? arf_q[lane_idx[k]] : '0;
            bus_io.retire_data[k]      = ret_v[k] ? data_q[lane_idx[k]] : '0;
        end
    end

    // Operand reads from registered state; unallocated ids read as not-ready, zero data.
    always_comb begin
        for (int r = 0; r < N_RD; r++) begin
            bus_io.rd_ready[r] = valid_q[bus_io.rd_rob_id[r]] && ready_q[bus_io.rd_rob_id[r]];
            bus_io.rd_data[r]  = valid_q[bus_io.rd_rob_id[r]] ? data_q[bus_io.rd_rob_id[r]] : '0;
`ifdef ROB_WB_BYPASS_EN
            for (int p = 0; p < N_WAKE; p++) begin
                if (bus_io.wake_valid[p] && (bus_io.wake_rob_id[p] == bus_io.rd_rob_id[r])) begin
                    bus_io.rd_ready[r] = 1'b1;
                end
            end
            // Writeback ports are scanned last so their data overrides a wake-only match.
            for (int p = 0; p < N_WB; p++) begin
                if (bus_io.wb_valid[p] && (bus_io.wb_rob_id[p] == bus_io.rd_rob_id[r])) begin
                    bus_io.rd_ready[r] = 1'b1;
                    bus_io.rd_data[r]  = bus_io.wb_data[p];
                end
            end
`endif
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst_aH) count_q == PTR_W'(tail_q - head_q));
    for (genvar p = 0; p < N_WB; p++) begin : g_wb_chk
        assert property (@(posedge clk) disable iff (rst_aH)
            bus_io.wb_valid[p] |-> valid_q[bus_io.wb_rob_id[p]]);
        for (genvar q = p + 1; q < N_WB; q++) begin : g_wb_uniq
            assert property (@(posedge clk) disable iff (rst_aH)
                !(bus_io.wb_valid[p] && bus_io.wb_valid[q] &&
                  (bus_io.wb_rob_id[p] == bus_io.wb_rob_id[q])));
        end
    end
`endif
endmodule

// File: tb/tb_rob_mw.sv
module tb_rob_mw;
    localparam int DEPTH = 16;
    localparam int RET_W = 2;
    localparam int N_WB  = 2;
    localparam int N_RD  = 2;

    logic clk    = 1'b0;
    logic rst_aH = 1'b1;
    always #5 clk = ~clk;

    rob_mw_if #(.DEPTH(16)) bus  ();
    rob_mw_if #(.DEPTH(4))  bus4 ();

    rob_mw #(.DEPTH(16)) u_dut  (.clk(clk), .rst_aH(rst_aH), .bus_io(bus.slave));
    rob_mw #(.DEPTH(4))  u_dut4 (.clk(clk), .rst_aH(rst_aH), .bus_io(bus4.slave));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        dst;
        logic [4:0]  arf;
        logic        rdy;
        logic        done;
        logic [31:0] data;
        logic        mp;
        logic [31:0] npc;
    } ent_t;

    typedef struct {
        logic        wbv;
        logic [3:0]  wbid;
        logic [31:0] wbd;
        logic [1:0]  exp_rv;
        logic [3:0]  exp_id0;
        logic [31:0] exp_d0;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.dispatch_valid      = 1'b0;
        bus.dispatch_dst_valid  = 1'b0;
        bus.dispatch_dst_arf_id = '0;
        bus.dispatch_pc         = '0;
        bus.wake_valid          = '0;
        bus.wake_rob_id         = '0;
        bus.wb_valid            = '0;
        bus.wb_rob_id           = '0;
        bus.wb_data             = '0;
        bus.wb_mispred          = '0;
        bus.wb_npc              = '0;
        bus.rd_rob_id           = '0;
    endtask

    task automatic idle4();
        bus4.dispatch_valid      = 1'b0;
        bus4.dispatch_dst_valid  = 1'b0;
        bus4.dispatch_dst_arf_id = '0;
        bus4.dispatch_pc         = '0;
        bus4.wake_valid          = '0;
        bus4.wake_rob_id         = '0;
        bus4.wb_valid            = '0;
        bus4.wb_rob_id           = '0;
        bus4.wb_data             = '0;
        bus4.wb_mispred          = '0;
        bus4.wb_npc              = '0;
        bus4.rd_rob_id           = '0;
    endtask

    // Leaves the caller at a falling edge with idle inputs.
    task automatic do_reset();
        idle();
        idle4();
        rst_aH = 1'b1;
        @(negedge clk);
        rst_aH = 1'b0;
    endtask

    task automatic dispatch_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.dispatch_valid      = 1'b1;
            bus.dispatch_dst_valid  = 1'b1;
            bus.dispatch_dst_arf_id = 5'(i + 1);
            bus.dispatch_pc         = 32'(i * 4);
            @(negedge clk);
        end
        idle();
    endtask

    task automatic run_random(input int cycles);
        ent_t mq[$];
        int   mhead = 0;
        for (int c = 0; c < cycles; c++) begin
            int   size, nret, off, id;
            logic eflush, eready, er;
            logic [31:0] ed;
            int   pend[$];
            idle();
            size = mq.size();
            bus.dispatch_valid      = ($urandom_range(0, 9) < 7);
            bus.dispatch_dst_valid  = 1'($urandom_range(0, 1));
            bus.dispatch_dst_arf_id = 5'($urandom_range(0, 31));
            bus.dispatch_pc         = $urandom;
            if (size > 0 && $urandom_range(0, 3) == 0) begin
                bus.wake_valid[0]  = 1'b1;
                bus.wake_rob_id[0] = 4'((mhead + $urandom_range(0, size - 1)) % DEPTH);
            end
            for (int i = 0; i < size; i++) if (!mq[i].done) pend.push_back(i);
            for (int p = 0; p < N_WB; p++) begin
                if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int j;
                    j = $urandom_range(0, pend.size() - 1);
                    bus.wb_valid[p]   = 1'b1;
                    bus.wb_rob_id[p]  = 4'((mhead + pend[j]) % DEPTH);
                    bus.wb_data[p]    = $urandom;
                    bus.wb_mispred[p] = ($urandom_range(0, 19) == 0);
                    bus.wb_npc[p]     = $urandom;
                    pend.delete(j);
                end
            end
            for (int r = 0; r < N_RD; r++) bus.rd_rob_id[r] = 4'($urandom_range(0, DEPTH - 1));
            #1;
            eflush = (size > 0) && mq[0].done && mq[0].mp;
            nret = 0;
            while (nret < RET_W && nret < size && mq[nret].done && !mq[nret].mp) nret++;
            eready = (size < DEPTH) && !eflush;
            chk("rnd_ready", bus.dispatch_ready, eready);
            chk("rnd_rob_id", bus.dispatch_rob_id, (mhead + size) % DEPTH);
            chk("rnd_flush", bus.flush, eflush);
            chk("rnd_flush_pc", bus.flush_pc, eflush ? mq[0].npc : 0);
            for (int k = 0; k < RET_W; k++) begin
                chk("rnd_ret_v", bus.retire_valid[k], k < nret);
                if (k < nret) begin
                    chk("rnd_ret_id", bus.retire_rob_id[k], (mhead + k) % DEPTH);
                    chk("rnd_ret_dst", bus.retire_dst_valid[k], mq[k].dst);
                    chk("rnd_ret_arf", bus.retire_arf_id[k], mq[k].arf);
                    chk("rnd_ret_data", bus.retire_data[k], mq[k].data);
                end
            end
            for (int r = 0; r < N_RD; r++) begin
                id  = int'(bus.rd_rob_id[r]);
                off = (id - mhead + DEPTH) % DEPTH;
                er  = 1'b0;
                ed  = '0;
                if (off < size) begin
                    er = mq[off].rdy;
                    ed = mq[off].data;
                end
`ifdef ROB_WB_BYPASS_EN
                if (bus.wake_valid[0] && bus.wake_rob_id[0] == bus.rd_rob_id[r]) er = 1'b1;
                for (int p = 0; p < N_WB; p++) begin
                    if (bus.wb_valid[p] && bus.wb_rob_id[p] == bus.rd_rob_id[r]) begin
                        er = 1'b1;
                        ed = bus.wb_data[p];
                    end
                end
`endif
                chk("rnd_rd_ready", bus.rd_ready[r], er);
                chk("rnd_rd_data", bus.rd_data[r], ed);
            end
            @(posedge clk);
            if (eflush) begin
                mq.delete();
                mhead = 0;
            end else begin
                if (bus.wake_valid[0]) begin
                    off = (int'(bus.wake_rob_id[0]) - mhead + DEPTH) % DEPTH;
                    if (off < size) mq[off].rdy = 1'b1;
                end
                for (int p = 0; p < N_WB; p++) begin
                    if (bus.wb_valid[p]) begin
                        off = (int'(bus.wb_rob_id[p]) - mhead + DEPTH) % DEPTH;
                        mq[off].rdy  = 1'b1;
                        mq[off].done = 1'b1;
                        mq[off].data = bus.wb_data[p];
                        mq[off].mp   = bus.wb_mispred[p];
                        mq[off].npc  = bus.wb_npc[p];
                    end
                end
                for (int k = 0; k < nret; k++) void'(mq.pop_front());
                mhead = (mhead + nret) % DEPTH;
                if (bus.dispatch_valid && eready) begin
                    mq.push_back('{bus.dispatch_dst_valid, bus.dispatch_dst_arf_id,
                                   1'b0, 1'b0, 32'h0, 1'b0, 32'h0});
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    vec_t tv [6];

    initial begin
        idle();
        idle4();
        @(negedge clk);

        // T1: reset mid-stream
        do_reset();
        dispatch_n(5);
        chk("t1_pre_id", bus.dispatch_rob_id, 5);
        bus.dispatch_valid = 1'b1;
        rst_aH = 1'b1;
        #1;
        chk("t1_async_id", bus.dispatch_rob_id, 0);
        @(posedge clk);
        #1;
        chk("t1_id", bus.dispatch_rob_id, 0);
        chk("t1_ready", bus.dispatch_ready, 1);
        chk("t1_ret_v", bus.retire_valid, 0);
        chk("t1_ret_id", bus.retire_rob_id, 0);
        chk("t1_flush", bus.flush, 0);
        chk("t1_flush_pc", bus.flush_pc, 0);
        chk("t1_rd_ready", bus.rd_ready, 0);
        @(negedge clk);
        idle();
        rst_aH = 1'b0;

        // T2: fill to DEPTH, then a 17th request is refused
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.dispatch_valid = 1'b1;
            #1;
            chk("t2_ready", bus.dispatch_ready, i < 16);
            if (i < 16) chk("t2_id", bus.dispatch_rob_id, i);
            @(negedge clk);
        end
        idle();
        #1;
        chk("t2_full_ready", bus.dispatch_ready, 0);
        chk("t2_ret_v", bus.retire_valid, 0);

        // T3: out-of-order writeback, table-driven
        tv[0] = '{1'b1, 4'd2, 32'h22, 2'b00, 4'd0, 32'h0};
        tv[1] = '{1'b1, 4'd1, 32'h11, 2'b00, 4'd0, 32'h0};
        tv[2] = '{1'b1, 4'd0, 32'h10, 2'b00, 4'd0, 32'h0};
        tv[3] = '{1'b0, 4'd0, 32'h0,  2'b11, 4'd0, 32'h10};
        tv[4] = '{1'b0, 4'd0, 32'h0,  2'b01, 4'd2, 32'h22};
        tv[5] = '{1'b0, 4'd0, 32'h0,  2'b00, 4'd0, 32'h0};
        @(negedge clk);
        do_reset();
        dispatch_n(3);
        for (int i = 0; i < 6; i++) begin
            idle();
            bus.wb_valid[0]  = tv[i].wbv;
            bus.wb_rob_id[0] = tv[i].wbid;
            bus.wb_data[0]   = tv[i].wbd;
            #1;
            chk("t3_ret_v", bus.retire_valid, tv[i].exp_rv);
            if (tv[i].exp_rv[0]) begin
                chk("t3_ret_id0", bus.retire_rob_id[0], tv[i].exp_id0);
                chk("t3_ret_d0", bus.retire_data[0], tv[i].exp_d0);
            end
            if (tv[i].exp_rv[1]) chk("t3_ret_id1", bus.retire_rob_id[1], tv[i].exp_id0 + 1);
            @(negedge clk);
        end
        idle();

        // T4: wrap on the DEPTH=4 instance
        do_reset();
        for (int r = 0; r < 10; r++) begin
            bus4.dispatch_valid      = 1'b1;
            bus4.dispatch_dst_valid  = 1'b1;
            bus4.dispatch_dst_arf_id = 5'(r);
            #1;
            chk("t4_ready", bus4.dispatch_ready, 1);
            chk("t4_id", bus4.dispatch_rob_id, r % 4);
            @(negedge clk);
            idle4();
            bus4.wb_valid[0]  = 1'b1;
            bus4.wb_rob_id[0] = 2'(r % 4);
            bus4.wb_data[0]   = 32'(r + 100);
            @(negedge clk);
            idle4();
            #1;
            chk("t4_ret_v", bus4.retire_valid, 2'b01);
            chk("t4_ret_id", bus4.retire_rob_id[0], r % 4);
            chk("t4_ret_arf", bus4.retire_arf_id[0], r);
            chk("t4_ret_data", bus4.retire_data[0], r + 100);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            bus4.dispatch_valid = 1'b1;
            #1;
            chk("t4_fill_ready", bus4.dispatch_ready, i < 4);
            @(negedge clk);
        end
        idle4();

        // T5: mispredict behind a retiring head
        do_reset();
        dispatch_n(4);
        bus.wb_valid[0]   = 1'b1;
        bus.wb_rob_id[0]  = 4'd1;
        bus.wb_mispred[0] = 1'b1;
        bus.wb_npc[0]     = 32'h100;
        bus.wb_data[0]    = 32'h55;
        @(negedge clk);
        idle();
        bus.wb_valid[0]  = 1'b1;
        bus.wb_rob_id[0] = 4'd0;
        bus.wb_data[0]   = 32'h77;
        @(negedge clk);
        idle();
        #1;
        chk("t5_ret_v", bus.retire_valid, 2'b01);
        chk("t5_ret_id", bus.retire_rob_id[0], 0);
        chk("t5_no_flush", bus.flush, 0);
        @(negedge clk);
        bus.dispatch_valid = 1'b1;
        #1;
        chk("t5_flush", bus.flush, 1);
        chk("t5_flush_pc", bus.flush_pc, 32'h100);
        chk("t5_flush_ret_v", bus.retire_valid, 0);
        chk("t5_flush_ready", bus.dispatch_ready, 0);
        @(negedge clk);
        idle();
        #1;
        chk("t5_after_flush", bus.flush, 0);
        chk("t5_after_id", bus.dispatch_rob_id, 0);
        chk("t5_after_ready", bus.dispatch_ready, 1);
        chk("t5_after_flush_pc", bus.flush_pc, 0);
        @(negedge clk);

        // T6: read of an entry being written back this cycle
        do_reset();
        dispatch_n(4);
        bus.wb_valid[0]  = 1'b1;
        bus.wb_rob_id[0] = 4'd3;
        bus.wb_data[0]   = 32'hABCD;
        bus.rd_rob_id[0] = 4'd3;
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("t6_same_ready", bus.rd_ready[0], 1);
        chk("t6_same_data", bus.rd_data[0], 32'hABCD);
`else
        chk("t6_same_ready", bus.rd_ready[0], 0);
        chk("t6_same_data", bus.rd_data[0], 0);
`endif
        @(negedge clk);
        idle();
        bus.rd_rob_id[0] = 4'd3;
        bus.rd_rob_id[1] = 4'd9;
        #1;
        chk("t6_next_ready", bus.rd_ready[0], 1);
        chk("t6_next_data", bus.rd_data[0], 32'hABCD);
        chk("t6_unalloc_ready", bus.rd_ready[1], 0);
        chk("t6_unalloc_data", bus.rd_data[1], 0);
        @(negedge clk);

        // Randomized traffic against the queue model
        do_reset();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
